// File: rtl/line_unbuffer.sv
// line_unbuffer
// -------------
// Parallel-to-serial unpacker. A whole line of NUM packed elements is taken
// in one load handshake. The elements then leave one per cycle on a
// valid/ready stream, element 0 first. A shadow register holds one pending
// line, so that consecutive lines stream out with no bubble between them.
//
// Ports
//   clk        in   clock, every register updates on posedge
//   rstn       in   synchronous active-low reset
//   din        in   packed line, element i = din[DATA_WIDTH*i +: DATA_WIDTH]
//   load       in   din holds a valid line
//   load_ready out  a line can be accepted this cycle
//   dout       out  current element
//   dout_valid out  dout holds a valid element
//   dout_ready in   consumer takes dout this cycle
//   dout_idx   out  index of the element on dout
//   dout_last  out  the element on dout is the last one of its line
//   busy       out  an active line (and possibly a shadow line) is held
module line_unbuffer #(
  parameter int DATA_WIDTH = 8,
  parameter int NUM        = 16,
  parameter int IDX_W      = $clog2(NUM)
) (
  input  logic                      clk,
  input  logic                      rstn,
  input  logic [DATA_WIDTH*NUM-1:0] din,
  input  logic                      load,
  output logic                      load_ready,
  output logic [DATA_WIDTH-1:0]     dout,
  output logic                      dout_valid,
  input  logic                      dout_ready,
  output logic [IDX_W-1:0]          dout_idx,
  output logic                      dout_last,
  output logic                      busy
);

  localparam int LINE_W = DATA_WIDTH * NUM;

  typedef enum logic [1:0] {
    EMPTY,
    SEND,
    SEND_PEND
  } state_t;

  state_t              state_q, state_d;
  logic [IDX_W-1:0]    count_q, count_d;
  logic [LINE_W-1:0]   active_q, active_d;
  logic [LINE_W-1:0]   shadow_q, shadow_d;

  logic loadFire;
  logic outFire;
  logic atLast;

  // The shadow register is occupied exactly when the FSM sits in SEND_PEND,
  // so both the ready and the status outputs come straight from the state.
  assign load_ready = (state_q != SEND_PEND);
  assign dout_valid = (state_q != EMPTY);
  assign busy       = (state_q != EMPTY);

  assign loadFire = load && load_ready;
  assign outFire  = dout_valid && dout_ready;
  assign atLast   = (count_q == IDX_W'(NUM - 1));

  assign dout      = active_q[DATA_WIDTH*count_q +: DATA_WIDTH];
  assign dout_idx  = count_q;
  assign dout_last = dout_valid && atLast;

  // State, element counter and line registers; reset discards both the
  // active and the shadow line.
  always_ff @(posedge clk) begin
    if (!rstn) begin
      state_q  <= EMPTY;
      count_q  <= '0;
      active_q <= '0;
      shadow_q <= '0;
    end else begin
      state_q  <= state_d;
      count_q  <= count_d;
      active_q <= active_d;
      shadow_q <= shadow_d;
    end
  end

  // Next-state logic. On the last-element transfer of a line the next line
  // is taken either from din (same-cycle load with an empty shadow) or from
  // the shadow register, so the stream never drops a cycle.
  always_comb begin
    state_d  = state_q;
    count_d  = count_q;
    active_d = active_q;
    shadow_d = shadow_q;
    case (state_q)
      EMPTY: begin
        if (loadFire) begin
          active_d = din;
          count_d  = '0;
          state_d  = SEND;
        end
      end
      SEND: begin
        if (outFire && atLast) begin
          count_d = '0;
          if (loadFire) begin
            active_d = din;
          end else begin
            state_d = EMPTY;
          end
        end else begin
          if (outFire) begin
            count_d = count_q + IDX_W'(1);
          end
          if (loadFire) begin
            shadow_d = din;
            state_d  = SEND_PEND;
          end
        end
      end
      SEND_PEND: begin
        if (outFire) begin
          if (atLast) begin
            active_d = shadow_q;
            count_d  = '0;
            state_d  = SEND;
          end else begin
            count_d = count_q + IDX_W'(1);
          end
        end
      end
      default: begin
        state_d = EMPTY;
        count_d = '0;
      end
    endcase
  end

endmodule
